// File: rtl/caeser_pkg.sv
// +-----------------------------------------------------------------------+
// | caeser_pkg : state encodings, default widths and key helper shared     |
// |              by the Caesar encryptor and decryptor.  Rev 1.0           |
// +-----------------------------------------------------------------------+
`default_nettype none

package caeser_pkg;

    localparam int unsigned c_d_width   = 8;
    localparam int unsigned c_key_width = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Plain truncation: the decryptor subtracts the same low bits, so no mod-26.
    function automatic logic [c_d_width-1:0] key_trunc(input logic [c_key_width-1:0] key_full);
        return key_full[c_d_width-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/caeser_fifo.sv
// +-----------------------------------------------------------------------+
// | caeser_fifo : synchronous FIFO with occupancy count, power-of-2 depth. |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module caeser_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w:0]   count_q, count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (count_q == (c_ptr_w+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rd_data   = mem_q[rd_ptr_q];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + (c_ptr_w+1)'(1);
        end else if (w_do_pop && !w_do_push) begin
            count_d = count_q - (c_ptr_w+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/caeser_enc.sv
// +-----------------------------------------------------------------------+
// | caeser_enc : Caesar encryptor; keyed add at push time, FIFO-buffered   |
// |              valid-qualified ciphertext stream.  Rev 1.0               |
// +-----------------------------------------------------------------------+
`default_nettype none

module caeser_enc
    import caeser_pkg::*;
#(
    parameter int unsigned D_WIDTH   = c_d_width,
    parameter int unsigned KEY_WIDTH = c_key_width,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 key_load,
    input  logic [D_WIDTH-1:0]   data_in,
    input  logic                 valid_in,
    input  logic                 eom_in,
    output logic                 ready_in,
    input  logic                 out_hold,
    output logic [D_WIDTH-1:0]   data_e,
    output logic                 valid_e,
    output logic                 eom_out,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic [D_WIDTH-1:0]   key_q, key_d;
    logic [D_WIDTH-1:0]   data_e_q, data_e_d;
    logic                 valid_e_q, valid_e_d;
    logic                 eom_out_q, eom_out_d;

    logic [D_WIDTH-1:0]   w_key_trunc;
    logic [D_WIDTH-1:0]   w_enc;
    logic [D_WIDTH:0]     w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                 w_push;
    logic                 w_pop;

    generate
        if (D_WIDTH == c_d_width && KEY_WIDTH == c_key_width) begin : g_key_pkg
            assign w_key_trunc = key_trunc(key);
        end else begin : g_key_slice
            assign w_key_trunc = key[D_WIDTH-1:0];
        end
    endgenerate

    assign w_enc    = data_in + key_q;
    assign ready_in = (state_q == RUN) && !w_full;
    assign w_push   = valid_in && ready_in;
    assign w_pop    = !w_empty && !out_hold;

    caeser_fifo #(
        .WIDTH (D_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data ({eom_in, w_enc}),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        valid_e_d = 1'b0;
        data_e_d  = '0;
        eom_out_d = 1'b0;

        if (w_pop) begin
            valid_e_d = 1'b1;
            data_e_d  = w_head[D_WIDTH-1:0];
            eom_out_d = w_head[D_WIDTH];
        end

        case (state_q)
            IDLE: begin
                if (key_load) begin
                    key_d   = w_key_trunc;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_push && eom_in) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The eom entry is the last one pushed, so it is on the output now.
                if (w_count == '0 && valid_e_q && eom_out_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            key_q     <= '0;
            data_e_q  <= '0;
            valid_e_q <= 1'b0;
            eom_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            data_e_q  <= data_e_d;
            valid_e_q <= valid_e_d;
            eom_out_q <= eom_out_d;
        end
    end

    assign data_e  = data_e_q;
    assign valid_e = valid_e_q;
    assign eom_out = eom_out_q;
    assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: doc/caeser_enc.md
Name: caeser_enc

Overview:
Upstream encryption stage for the Caesar decryptor. It accepts a plaintext string one character at a time over a valid/ready handshake. Each character is encrypted with the key latched at message start, then buffered in a small FIFO. The block emits a valid-qualified ciphertext stream (data_e/valid_e), which connects directly to the decryptor's data_e/valid_e inputs. The decryptor has no backpressure, so out_hold is the only throttle on the output side.

Parameters:
D_WIDTH, 8, character width in bits.
KEY_WIDTH, 16, key input width; only the low D_WIDTH bits are used.
DEPTH, 8, FIFO depth in characters; must be a power of 2 and at least 2.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
key  in  KEY_WIDTH  encryption key.
key_load  in  1  latches key and starts a message; honoured in IDLE only.
data_in  in  D_WIDTH  plaintext character.
valid_in  in  1  data_in is valid.
eom_in  in  1  marks the last character of the message; qualified by valid_in.
ready_in  out  1  block can accept a character this cycle.
out_hold  in  1  stalls output pops.
data_e  out  D_WIDTH  ciphertext character.
valid_e  out  1  data_e is valid.
eom_out  out  1  data_e is the last character of the message.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low, on reset_n.
- Reset values:
  - state = IDLE; FIFO empty.
  - Internal key register = 0.
  - ready_in = 0, valid_e = 0, data_e = 0, eom_out = 0, busy = 0.
- Encryption: enc = (data_in + key[D_WIDTH-1:0]) mod 2^D_WIDTH.
  - The key is truncated, not reduced mod 26; this is the exact inverse of the decryptor's subtraction.
  - Encryption happens at push time. The FIFO stores {eom_in, enc}, D_WIDTH+1 bits wide.
- FSM states and transitions:
  - IDLE: ready_in = 0. key_load = 1 latches key and moves to RUN on the next edge. valid_in is ignored.
  - RUN: ready_in = !full, driven from the FIFO count only (no bypass when full).
    - A handshake is valid_in & ready_in; it pushes one entry.
    - A push with eom_in = 1 moves to DRAIN.
    - key_load is ignored.
  - DRAIN: ready_in = 0. Pops continue. Moves to IDLE on the edge where the FIFO is empty and the final eom entry has been emitted.
    - busy drops the cycle after the eom character's valid_e pulse.
- Output, all registered:
  - At each edge, if FIFO is not empty and out_hold = 0: pop, then valid_e = 1, data_e = head data, eom_out = head eom.
  - Otherwise valid_e = 0, data_e = 0, eom_out = 0.
  - A non-empty FIFO with out_hold low yields one character per cycle, back-to-back.
- Latency: a character accepted at edge k into an empty FIFO appears on valid_e/data_e after edge k+1.
- Boundary conditions:
  - Simultaneous push and pop: allowed whenever the FIFO is neither full nor empty; count is unchanged.
  - Full: ready_in = 0, so no push. A pop that same cycle raises ready_in on the following cycle.
  - Empty with out_hold = 0: valid_e = 0.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
  - eom_in without valid_in is ignored.
  - key_load together with valid_in in IDLE: the key is latched; the character is not accepted (ready_in = 0).
  - reset_n low mid-message: outputs clear immediately; FIFO contents and state are discarded.

Decomposition:
- Shared package caeser_pkg: FSM state encodings (IDLE/RUN/DRAIN), default D_WIDTH/KEY_WIDTH constants, and a key-truncation helper function. The decryptor uses the same package.
- One sub-module, caeser_fifo: synchronous FIFO parameterised by WIDTH and DEPTH, with push, pop, full, empty and count.
- The FSM, key register and adder stay in caeser_enc.

Test Plan:
1. Basic message: reset, then key_load with key=16'h0003. Send 0x48, then 0x49 with eom_in=1.
   -> data_e = 0x4B then 0x4C on consecutive cycles; eom_out=1 on the second only; busy=0 afterwards.
2. Wrap-around: key=16'h0105, send 0xFD with eom_in=1.
   -> data_e=0x02, proving only the low 8 bits of the key are used.
3. Full and drain: out_hold=1, key=0, offer 9 characters 0x00..0x08.
   -> ready_in=0 after the 8th is accepted; the 9th is not accepted.
   -> Release hold: 0x00..0x07 emitted on 8 consecutive cycles; 0x08 is accepted once space frees.
4. No key loaded: valid_in=1 with data 0x41 while in IDLE.
   -> ready_in=0, no valid_e.
   -> Then key_load with key=1 while in RUN and key_load with key=5 mid-message: later output still uses key=1.
5. Reset mid-stream: 3 characters buffered with out_hold=1, then pulse reset_n low asynchronously (between edges).
   -> valid_e, busy and ready_in are 0 immediately.
   -> After release, no stale output even with out_hold=0.
6. Loopback: connect to the decryptor with the same key=16'h0007 and send "HELLO" (0x48 0x45 0x4C 0x4C 0x4F).
   -> Decryptor data_d reproduces 0x48 0x45 0x4C 0x4C 0x4F in order.
